// File: rtl/y_stream_gen.sv
// y_stream_gen: paces luma pixels from a FWFT FIFO onto a programmable raster (y_vs / y_de / y_data_en / y_data).
// Latency: raster outputs are registered one clk after the counter state that produces them; src_rd_en is combinational.
// Backpressure: none toward the sink; an empty FIFO never stalls the raster, a zero pixel is substituted and underflow latches.
module y_stream_gen #(
  parameter int COL     = 640,
  parameter int ROW     = 480,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_BP    = 144,
  parameter int V_BP    = 35,
  parameter int VS_LEN  = 2,
  parameter int PIX_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] src_data,
  input  logic       src_empty,
  output logic       src_rd_en,
  output logic       y_vs,
  output logic       y_de,
  output logic       y_data_en,
  output logic [7:0] y_data,
  output logic       frame_done,
  output logic       underflow
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LO = HW'(H_BP);
  localparam logic [HW-1:0] H_ACT_HI = HW'(H_BP + COL);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LO = VW'(V_BP);
  localparam logic [VW-1:0] V_ACT_HI = VW'(V_BP + ROW);
  localparam logic [VW-1:0] V_VS_END = VW'(VS_LEN);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [DW-1:0]  div_cnt;
  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;

  logic running;
  logic tick;
  logic h_last;
  logic v_last;
  logic eof_tick;
  logic sof_tick;
  logic vs_w;
  logic act;
  logic pix_due;

  // Raster decode: pixel tick, frame boundaries and active window, all from the current counters.
  always_comb begin
    running  = (state != IDLE);
    tick     = running && (div_cnt == DIV_LAST);
    h_last   = (h_cnt == H_LAST);
    v_last   = (v_cnt == V_LAST);
    eof_tick = tick && h_last && v_last;
    sof_tick = tick && (h_cnt == '0) && (v_cnt == '0);
    vs_w     = (v_cnt < V_VS_END);
    act      = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI) &&
               (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
    pix_due  = tick && act;
    // Never pop while reset is asserted, so an aborted frame leaves the FIFO untouched.
    src_rd_en = !rst && pix_due && !src_empty;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: enable only matters at the frame boundary, so frames are always emitted whole.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (eof_tick)     state_nxt = enable ? RUN : IDLE;
        else if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (eof_tick) state_nxt = enable ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel divider and raster counters; held at zero while idle, never stalled by the FIFO.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) begin
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end
      end
    end
  end

  // Registered raster outputs; y_data holds the last pixel between strobes.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      y_vs       <= 1'b0;
      y_de       <= 1'b0;
      y_data_en  <= 1'b0;
      y_data     <= 8'd0;
      frame_done <= 1'b0;
    end else begin
      y_vs       <= vs_w;
      y_de       <= act;
      y_data_en  <= pix_due;
      frame_done <= eof_tick;
      if (pix_due) begin
        y_data <= src_empty ? 8'd0 : src_data;
      end
    end
  end

  // Sticky underflow for the current frame; a starved pixel on the first tick wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (pix_due && src_empty) begin
      underflow <= 1'b1;
    end else if (sof_tick) begin
      underflow <= 1'b0;
    end
  end

endmodule
